// File: rtl/pulse_train_gen.sv
// pulse_train_gen: counted pulse-train generator with programmable high/low
// phase lengths, busy/done status, a running pulse counter and abort.
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] p_req,
   input  logic [LEN_W-1:0] hi_len,
   input  logic [LEN_W-1:0] lo_len,
   input  logic             abort,
   output logic             pulse,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] req_q, req_d;
   logic [LEN_W-1:0] hi_q, hi_d;
   logic [LEN_W-1:0] lo_q, lo_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // A programmed length of 0 behaves as a length of 1.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_ONE : len;
   endfunction

   // phase_q holds the cycles remaining in the current phase after this one,
   // so it is loaded with length-1 on phase entry and the phase ends at 0.
   // Next-state, counters and latched request.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, FIN: begin
               state_d = IDLE;
               // FIN is not busy, so a new train may start straight from it.
               if (start && !abort) begin
                  req_d = p_req;
                  hi_d  = hi_len;
                  lo_d  = lo_len;
                  if (p_req == '0) begin
                     state_d = FIN;
                     cnt_d   = '0;
                  end else begin
                     state_d = HIGH;
                     cnt_d   = CNT_ONE;
                     phase_d = eff_len(hi_len) - LEN_ONE;
                  end
               end
            end
            HIGH: begin
               if (phase_q == '0) begin
                  if (cnt_q == req_q) begin
                     state_d = FIN;
                  end else begin
                     state_d = LOW;
                     phase_d = eff_len(lo_q) - LEN_ONE;
                  end
               end else begin
                  phase_d = phase_q - LEN_ONE;
               end
            end
            LOW: begin
               if (phase_q == '0) begin
                  state_d = HIGH;
                  cnt_d   = cnt_q + CNT_ONE;
                  phase_d = eff_len(hi_q) - LEN_ONE;
               end else begin
                  phase_d = phase_q - LEN_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      pulse_d = (state_d == HIGH);
      busy_d  = (state_d == HIGH) || (state_d == LOW);
      done_d  = (state_d == FIN);
   end

   // State, counters and registered outputs; reset returns everything to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         cnt_q   <= '0;
         req_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pulse     = pulse_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: directed test-plan scenarios followed by
// random stimulus, all checked cycle by cycle against a sequence-based model.
module tb_pulse_train_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] p_req;
   logic [3:0] hi_len;
   logic [3:0] lo_len;
   logic       abort;
   logic       pulse;
   logic       busy;
   logic       done;
   logic [7:0] pulse_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic       p;
      logic       b;
      logic       d;
      logic [7:0] c;
   } out_t;

   out_t cur;
   out_t q[$];

   pulse_train_gen #(.CNT_W(8), .LEN_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .p_req(p_req), .hi_len(hi_len),
      .lo_len(lo_len), .abort(abort), .pulse(pulse), .busy(busy), .done(done),
      .pulse_cnt(pulse_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected output sequence of a whole accepted train, one entry per cycle.
   task automatic build(input int n, input int h, input int l);
      int he, le;
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      q.delete();
      if (n == 0) begin
         q.push_back('{p:1'b0, b:1'b0, d:1'b1, c:8'd0});
      end else begin
         for (int k = 1; k <= n; k++) begin
            for (int i = 0; i < he; i++) q.push_back('{p:1'b1, b:1'b1, d:1'b0, c:8'(k)});
            if (k < n)
               for (int i = 0; i < le; i++) q.push_back('{p:1'b0, b:1'b1, d:1'b0, c:8'(k)});
         end
         q.push_back('{p:1'b0, b:1'b0, d:1'b1, c:8'(n)});
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         q.delete();
         cur = '0;
      end else if ((cur.b || cur.d) && abort) begin
         q.delete();
         cur = '{p:1'b0, b:1'b0, d:1'b0, c:cur.c};
      end else if (!cur.b && start && !abort) begin
         build(int'(p_req), int'(hi_len), int'(lo_len));
         cur = q.pop_front();
      end else if (q.size() > 0) begin
         cur = q.pop_front();
      end else begin
         cur = '{p:1'b0, b:1'b0, d:1'b0, c:cur.c};
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pulse"}, 32'(pulse), 32'(cur.p));
      chk({tag, ".busy"}, 32'(busy), 32'(cur.b));
      chk({tag, ".done"}, 32'(done), 32'(cur.d));
      chk({tag, ".cnt"}, 32'(pulse_cnt), 32'(cur.c));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic go(input int n, input int h, input int l, input string tag);
      start  = 1'b1;
      p_req  = 8'(n);
      hi_len = 4'(h);
      lo_len = 4'(l);
      cycle(tag);
      start  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      p_req = '0; hi_len = '0; lo_len = '0;
      cur = '0;
      cycle("reset");
      cycle("reset");
      rst = 1'b0;
      idle(2, "post_reset");

      // p=3, hi=lo=1
      go(3, 1, 1, "t1");
      idle(8, "t1");
      // p=2, hi=3, lo=2 and the same with zero lengths mapping to 1
      go(2, 3, 2, "t2");
      idle(11, "t2");
      go(2, 0, 0, "t2z");
      idle(5, "t2z");
      // p=0
      go(0, 2, 2, "t3");
      idle(3, "t3");
      // ignored restart, then abort
      go(4, 1, 1, "t4");
      idle(2, "t4");
      start = 1'b1; p_req = 8'd9;
      cycle("t4_restart");
      start = 1'b0;
      idle(1, "t4");
      abort = 1'b1;
      cycle("t4_abort");
      abort = 1'b0;
      chk("t4_cnt_held", 32'(pulse_cnt), 32'd3);
      idle(4, "t4");
      // asynchronous reset mid-HIGH
      go(5, 3, 1, "t5");
      idle(1, "t5");
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_pulse", 32'(pulse), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_cnt", 32'(pulse_cnt), 32'd0);
      q.delete();
      cur = '0;
      cycle("t5_in_rst");
      rst = 1'b0;
      idle(6, "t5_after");
      // back-to-back through FIN
      go(1, 1, 1, "t6");
      idle(1, "t6");
      chk("t6_fin_done", 32'(done), 32'd1);
      go(2, 1, 1, "t6_b2b");
      chk("t6_no_overlap", 32'(pulse & done), 32'd0);
      idle(5, "t6");
      // abort together with start in FIN drops the start
      go(0, 1, 1, "t7");
      start = 1'b1; abort = 1'b1; p_req = 8'd3;
      cycle("t7_abort_start");
      idle(4, "t7");
      // maximum request: counter reaches 255 without wrapping
      go(255, 1, 1, "tmax");
      idle(512, "tmax");
      chk("tmax_cnt", 32'(pulse_cnt), 32'd255);

      // random stimulus
      for (int i = 0; i < 1500; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         abort  = ($urandom_range(0, 29) == 0);
         p_req  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 4));
         hi_len = 4'($urandom_range(0, 3));
         lo_len = 4'($urandom_range(0, 3));
         cycle("rand");
      end
      idle(40, "rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
